// File: rtl/clint_trap_ctrl.sv
// Core-local trap sequencer: accepts ecall/ebreak/mret and level interrupts, stalls the
// pipeline, writes mepc/mcause/mstatus one per cycle, then issues a one-cycle redirect.
module clint_trap_ctrl #(
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_addr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        timer_irq_i,
  input  logic        ext_irq_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        clint_wr_en_o,
  output logic [31:0] clint_wr_addr_o,
  output logic [31:0] clint_wr_data_o,
  output logic        hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    JUMP,
    R_MSTATUS,
    R_JUMP
  } state_t;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  state_t      state;
  logic [31:0] cause;
  logic [31:0] saved_status;

  logic        take_sync;
  logic        take_mret;
  logic        take_irq;
  logic        accept;
  logic [31:0] accept_cause;

  // Trap entry: stash MIE into MPIE, mask interrupts, record machine mode as previous.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and re-arm MPIE.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    take_sync    = 1'b0;
    take_mret    = 1'b0;
    take_irq     = 1'b0;
    accept_cause = CAUSE_TIMER;
    if (ecall_i || ebreak_i) begin
      take_sync    = 1'b1;
      accept_cause = ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
    end else if (mret_i) begin
      take_mret = 1'b1;
    end else if (csr_mstatus_i[3] && (ext_irq_i || timer_irq_i)) begin
      take_irq     = 1'b1;
      accept_cause = ext_irq_i ? CAUSE_EXT : CAUSE_TIMER;
    end
    accept = (state == IDLE) && (take_sync || take_mret || take_irq);
  end

  // The stall must reach the pipeline in the accept cycle itself, hence the combinational term.
  assign hold_flag_o = (state != IDLE) || accept;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cause           <= '0;
      saved_status    <= '0;
      clint_wr_en_o   <= 1'b0;
      clint_wr_addr_o <= '0;
      clint_wr_data_o <= '0;
      jump_flag_o     <= 1'b0;
      jump_addr_o     <= '0;
    end else begin
      clint_wr_en_o   <= 1'b0;
      clint_wr_addr_o <= '0;
      clint_wr_data_o <= '0;
      jump_flag_o     <= 1'b0;
      jump_addr_o     <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cause        <= accept_cause;
            saved_status <= csr_mstatus_i;
            clint_wr_en_o <= 1'b1;
            if (take_mret) begin
              state           <= R_MSTATUS;
              clint_wr_addr_o <= {20'd0, CSR_MSTATUS};
              clint_wr_data_o <= mret_mstatus(csr_mstatus_i);
            end else begin
              // The output data register doubles as the saved PC for the mepc write.
              state           <= W_MEPC;
              clint_wr_addr_o <= {20'd0, CSR_MEPC};
              clint_wr_data_o <= inst_addr_i;
            end
          end
        end
        W_MEPC: begin
          state           <= W_MCAUSE;
          clint_wr_en_o   <= 1'b1;
          clint_wr_addr_o <= {20'd0, CSR_MCAUSE};
          clint_wr_data_o <= cause;
        end
        W_MCAUSE: begin
          state           <= W_MSTATUS;
          clint_wr_en_o   <= 1'b1;
          clint_wr_addr_o <= {20'd0, CSR_MSTATUS};
          clint_wr_data_o <= trap_mstatus(saved_status);
        end
        W_MSTATUS: begin
          state       <= JUMP;
          jump_flag_o <= 1'b1;
          jump_addr_o <= csr_mtvec_i & ~32'd3;
        end
        R_MSTATUS: begin
          state       <= R_JUMP;
          jump_flag_o <= 1'b1;
          jump_addr_o <= csr_mepc_i;
        end
        JUMP, R_JUMP: state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Self-checking bench for clint_trap_ctrl: directed scenarios then randomized events,
// checked cycle by cycle against a transaction-level model of the trap/mret rules.
module tb_clint_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_addr_i;
  logic        ecall_i, ebreak_i, mret_i, timer_irq_i, ext_irq_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        clint_wr_en_o;
  logic [31:0] clint_wr_addr_o, clint_wr_data_o;
  logic        hold_flag_o, jump_flag_o;
  logic [31:0] jump_addr_o;

  int total = 0;
  int bad   = 0;

  // Model of the CSR unit's architectural state as seen by the bench.
  logic [31:0] m_mstatus, m_mtvec, m_mepc;

  clint_trap_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_addr_i     (inst_addr_i),
    .ecall_i         (ecall_i),
    .ebreak_i        (ebreak_i),
    .mret_i          (mret_i),
    .timer_irq_i     (timer_irq_i),
    .ext_irq_i       (ext_irq_i),
    .csr_mtvec_i     (csr_mtvec_i),
    .csr_mepc_i      (csr_mepc_i),
    .csr_mstatus_i   (csr_mstatus_i),
    .clint_wr_en_o   (clint_wr_en_o),
    .clint_wr_addr_o (clint_wr_addr_o),
    .clint_wr_data_o (clint_wr_data_o),
    .hold_flag_o     (hold_flag_o),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mstatus after trap entry: MPIE<-MIE, MIE<-0, MPP<-3
  function automatic logic [31:0] st_trap(input logic [31:0] s);
    return (s & ~32'h0000_1888) | (s[3] ? 32'h80 : 32'h0) | 32'h1800;
  endfunction

  // mstatus after mret: MIE<-MPIE, MPIE<-1, MPP<-3
  function automatic logic [31:0] st_mret(input logic [31:0] s);
    return (s & ~32'h0000_1888) | (s[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Noise on event lines while busy; the controller must ignore it.
  task automatic drive_junk();
    ecall_i     = ($urandom_range(0, 2) == 0);
    ebreak_i    = ($urandom_range(0, 2) == 0);
    mret_i      = ($urandom_range(0, 2) == 0);
    timer_irq_i = ($urandom_range(0, 1) == 0);
    ext_irq_i   = ($urandom_range(0, 1) == 0);
    inst_addr_i = $urandom;
  endtask

  task automatic clear_events();
    ecall_i = 0; ebreak_i = 0; mret_i = 0; timer_irq_i = 0; ext_irq_i = 0;
  endtask

  // One transaction: present the events for one accept cycle, then follow the whole sequence.
  task automatic run_txn(input logic ec, input logic eb, input logic mr,
                         input logic ti, input logic ei, input logic [31:0] pc);
    int          kind;  // 0 none, 1 trap, 2 mret
    logic [31:0] cause, new_st;
    next_cycle();
    ecall_i = ec; ebreak_i = eb; mret_i = mr; timer_irq_i = ti; ext_irq_i = ei;
    inst_addr_i   = pc;
    csr_mstatus_i = m_mstatus;
    csr_mtvec_i   = m_mtvec;
    csr_mepc_i    = m_mepc;
    kind = 0;
    cause = 0;
    if (ec || eb) begin
      kind = 1; cause = ec ? 32'd11 : 32'd3;
    end else if (mr) begin
      kind = 2;
    end else if (m_mstatus[3] && (ei || ti)) begin
      kind = 1; cause = ei ? 32'h8000_000B : 32'h8000_0007;
    end
    @(negedge clk);
    check("c0_hold", 32'(hold_flag_o), 32'(kind != 0));
    check("c0_wr_en", 32'(clint_wr_en_o), 0);
    check("c0_jump", 32'(jump_flag_o), 0);
    if (kind == 0) begin
      check("idle_addr", clint_wr_addr_o, 0);
      check("idle_data", clint_wr_data_o, 0);
    end
    if (kind == 1) begin
      new_st = st_trap(m_mstatus);
      for (int c = 1; c <= 4; c++) begin
        next_cycle();
        drive_junk();
        @(negedge clk);
        check("trap_hold", 32'(hold_flag_o), 1);
        if (c < 4) begin
          check("trap_wr_en", 32'(clint_wr_en_o), 1);
          check("trap_jump_low", 32'(jump_flag_o), 0);
          case (c)
            1: begin check("mepc_addr", clint_wr_addr_o, 32'h341); check("mepc_data", clint_wr_data_o, pc); end
            2: begin check("mcause_addr", clint_wr_addr_o, 32'h342); check("mcause_data", clint_wr_data_o, cause); end
            default: begin check("mstatus_addr", clint_wr_addr_o, 32'h300); check("mstatus_data", clint_wr_data_o, new_st); end
          endcase
        end else begin
          check("trap_jump_wr_en", 32'(clint_wr_en_o), 0);
          check("trap_jump", 32'(jump_flag_o), 1);
          check("trap_jump_addr", jump_addr_o, {m_mtvec[31:2], 2'b00});
        end
      end
      m_mstatus = new_st;
      m_mepc    = pc;
    end else if (kind == 2) begin
      new_st = st_mret(m_mstatus);
      next_cycle();
      drive_junk();
      @(negedge clk);
      check("mret_hold", 32'(hold_flag_o), 1);
      check("mret_wr_en", 32'(clint_wr_en_o), 1);
      check("mret_jump_low", 32'(jump_flag_o), 0);
      check("mret_st_addr", clint_wr_addr_o, 32'h300);
      check("mret_st_data", clint_wr_data_o, new_st);
      next_cycle();
      drive_junk();
      @(negedge clk);
      check("mret_hold2", 32'(hold_flag_o), 1);
      check("mret_jump_wr_en", 32'(clint_wr_en_o), 0);
      check("mret_jump", 32'(jump_flag_o), 1);
      check("mret_jump_addr", jump_addr_o, m_mepc);
      m_mstatus = new_st;
    end
  endtask

  initial begin
    rst_n = 0;
    clear_events();
    inst_addr_i = 0; csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
    m_mstatus = 0; m_mtvec = 0; m_mepc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 32'(clint_wr_en_o), 0);
    check("rst_addr", clint_wr_addr_o, 0);
    check("rst_data", clint_wr_data_o, 0);
    check("rst_hold", 32'(hold_flag_o), 0);
    check("rst_jump", 32'(jump_flag_o), 0);
    check("rst_jump_addr", jump_addr_o, 0);
    rst_n = 1;

    // ecall with MIE set
    m_mstatus = 32'h8; m_mtvec = 32'h201; m_mepc = 0;
    run_txn(1, 0, 0, 0, 0, 32'h100);
    // timer with MIE set
    m_mstatus = 32'h8;
    run_txn(0, 0, 0, 1, 0, 32'h40);
    // timer with MIE cleared by the previous trap: ignored
    run_txn(0, 0, 0, 1, 0, 32'h40);
    // external and timer together
    m_mstatus = 32'h8;
    run_txn(0, 0, 0, 1, 1, 32'h80);
    // mret
    m_mstatus = 32'h1880; m_mepc = 32'h44;
    run_txn(0, 0, 1, 0, 0, 32'h300);
    // ebreak beats mret and interrupts
    run_txn(0, 1, 1, 1, 1, 32'h500);
    // ecall with pending timer, then the timer stays masked by the written MIE=0
    m_mstatus = 32'h8;
    run_txn(1, 0, 0, 1, 0, 32'h60);
    run_txn(0, 0, 0, 1, 0, 32'h64);
    run_txn(0, 0, 0, 0, 0, 32'h68);

    // Reset while in W_MCAUSE aborts the sequence
    m_mstatus = 32'h8;
    next_cycle();
    ecall_i = 1; inst_addr_i = 32'h200; csr_mstatus_i = m_mstatus;
    @(negedge clk);
    check("abort_c0_hold", 32'(hold_flag_o), 1);
    next_cycle();
    clear_events();
    @(negedge clk);
    check("abort_mepc_wr", 32'(clint_wr_en_o), 1);
    next_cycle();
    @(negedge clk);
    check("abort_mcause_wr", 32'(clint_wr_addr_o), 32'h342);
    rst_n = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_rst_wr_en", 32'(clint_wr_en_o), 0);
      check("abort_rst_jump", 32'(jump_flag_o), 0);
      check("abort_rst_hold", 32'(hold_flag_o), 0);
    end
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_after_wr_en", 32'(clint_wr_en_o), 0);
      check("abort_after_jump", 32'(jump_flag_o), 0);
    end

    // Randomized traffic, back-to-back through the model
    for (int i = 0; i < 200; i++) begin
      logic ec, eb, mr, ti, ei;
      ec = ($urandom_range(0, 5) == 0);
      eb = ($urandom_range(0, 5) == 0);
      mr = ($urandom_range(0, 4) == 0);
      ti = ($urandom_range(0, 2) == 0);
      ei = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) m_mstatus = $urandom;
      if ($urandom_range(0, 4) == 0) m_mepc = $urandom;
      m_mtvec = $urandom;
      run_txn(ec, eb, mr, ti, ei, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
